ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 16K x 32 word RAM between the instruction-fetch port and the load/store data port of the processor. Data accesses win by fixed priority, and a starvation counter forces an instruction grant after a bounded run of data grants. The block drives the RAM's address, write-enable and write-data inputs. It returns registered read data and a one-cycle completion pulse to the granted requester.

---
 rtl/ram_arbiter_pkg.sv | 29 ++
 rtl/ram_arbiter.sv | 78 +++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the instruction/data RAM arbiter and the 16K x 32 RAM it fronts.
// The starvation-count update lives here so the rule is stated once for the whole subsystem.
package ram_arbiter_pkg;

    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_STARVE = 3;
    localparam int RAM_DEPTH      = 1 << DEF_ADDR_W;
    localparam int STARVE_W       = 4;

    // Count data grants that bypass a waiting fetch; any fetch grant or idle fetch port restarts it.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic                ireq,
        input logic                igrant,
        input logic                dgrant,
        input logic [STARVE_W-1:0] cur,
        input logic [STARVE_W-1:0] limit
    );
        logic [STARVE_W-1:0] nxt;
        nxt = cur;
        if (igrant || !ireq) begin
            nxt = '0;
        end else if (dgrant && (cur < limit)) begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Fixed-priority arbiter sharing one single-ported RAM between instruction fetch and load/store.
// Data wins unless a fetch has already been passed over MAX_STARVE times in a row.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STARVE = DEF_MAX_STARVE
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddress,
    output logic              IGnt,
    output logic              IValid,
    output logic [DATA_W-1:0] IReadData,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddress,
    input  logic [DATA_W-1:0] DWriteData,
    output logic              DGnt,
    output logic              DValid,
    output logic [DATA_W-1:0] DReadData,
    output logic [ADDR_W-1:0] RamAddress,
    output logic              RamMemWrite,
    output logic [DATA_W-1:0] RamWriteData,
    input  logic [DATA_W-1:0] RamReadData
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                ivalid_q, ivalid_d;
    logic                dvalid_q, dvalid_d;
    logic [DATA_W-1:0]   irdata_q, irdata_d;
    logic [DATA_W-1:0]   drdata_q, drdata_d;
    logic                igrant, dgrant;

    always_comb begin
        igrant = IReq && ((starve_q == STARVE_LIMIT) || !DReq);
        dgrant = DReq && !igrant;

        starve_d = starve_next(IReq, igrant, dgrant, starve_q, STARVE_LIMIT);

        // Valids are single-cycle pulses; read data holds until the port's next read completes.
        ivalid_d = igrant;
        dvalid_d = dgrant;
        irdata_d = igrant ? RamReadData : irdata_q;
        drdata_d = (dgrant && !DWe) ? RamReadData : drdata_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starve_q <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign IGnt         = igrant;
    assign DGnt         = dgrant;
    assign IValid       = ivalid_q;
    assign DValid       = dvalid_q;
    assign IReadData    = irdata_q;
    assign DReadData    = drdata_q;
    assign RamAddress   = dgrant ? DAddress : IAddress;
    assign RamMemWrite  = dgrant && DWe;
    assign RamWriteData = DWriteData;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a behavioural RAM, a reference memory and grant model,
// and a scoreboard monitor that matches every Valid pulse against the queued expectation.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int LIMIT = DEF_MAX_STARVE;

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
        time           t;
    } exp_t;

    logic          Clock;
    logic          Reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          IGnt, IValid;
    logic [DW-1:0] IReadData;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          DGnt, DValid;
    logic [DW-1:0] DReadData;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] ram     [RAM_DEPTH];
    logic [DW-1:0] ref_mem [RAM_DEPTH];

    exp_t exp_i[$];
    exp_t exp_d[$];

    int   checks = 0;
    int   passed = 0;
    int   fetch_passed_over = 0;
    logic i_done = 1'b0;
    logic d_done = 1'b0;
    logic count_en = 1'b0;
    int   n_ig = 0;
    int   n_dg = 0;
    logic [DW-1:0] last_i = '0;
    logic [DW-1:0] last_d = '0;

    ram_arbiter dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .IReq         (i_req),
        .IAddress     (i_addr),
        .IGnt         (IGnt),
        .IValid       (IValid),
        .IReadData    (IReadData),
        .DReq         (d_req),
        .DWe          (d_we),
        .DAddress     (d_addr),
        .DWriteData   (d_wdata),
        .DGnt         (DGnt),
        .DValid       (DValid),
        .DReadData    (DReadData),
        .RamAddress   (ram_addr),
        .RamMemWrite  (ram_we),
        .RamWriteData (ram_wdata),
        .RamReadData  (ram_rdata)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign ram_rdata = ram[ram_addr];
    always @(posedge Clock) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    initial begin
        for (int k = 0; k < RAM_DEPTH; k++) begin
            ram[k]     <= (32'(k) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
            ref_mem[k]  = (32'(k) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        end
        ram[5]     <= 32'hDEAD_BEEF;
        ref_mem[5]  = 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // Reference model: data has priority, except that a fetch passed over LIMIT times gets the RAM.
    always @(negedge Clock) begin
        logic gi, gd;
        if (Reset) begin
            fetch_passed_over = 0;
            i_done = 1'b0;
            d_done = 1'b0;
        end else begin
            gi = i_req && (!d_req || fetch_passed_over >= LIMIT);
            gd = d_req && !gi;
            chk("igrant", 32'(IGnt), 32'(gi));
            chk("dgrant", 32'(DGnt), 32'(gd));
            chk("ram_write", 32'(ram_we), 32'(gd && d_we));
            chk("ram_addr", 32'(ram_addr), 32'(gd ? d_addr : i_addr));
            if (gd) chk("ram_wdata", ram_wdata, d_wdata);
            if (gi) exp_i.push_back('{1'b0, ref_mem[i_addr], $time});
            if (gd) begin
                exp_d.push_back('{d_we, d_we ? '0 : ref_mem[d_addr], $time});
                if (d_we) ref_mem[d_addr] = d_wdata;
            end
            if (count_en) begin
                n_ig += int'(IGnt);
                n_dg += int'(DGnt);
            end
            if (gi || !i_req) fetch_passed_over = 0;
            else if (gd) fetch_passed_over++;
            i_done = gi;
            d_done = gd;
        end
    end

    // Scoreboard monitor: entries pushed at this same edge are not yet due.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset) begin
            chk("rst_ivalid", 32'(IValid), 32'd0);
            chk("rst_dvalid", 32'(DValid), 32'd0);
            chk("rst_irdata", IReadData, 32'd0);
            chk("rst_drdata", DReadData, 32'd0);
            exp_i.delete();
            exp_d.delete();
            last_i = '0;
            last_d = '0;
        end else begin
            if (IValid) begin
                if (exp_i.size() == 0 || exp_i[0].t >= $time) begin
                    chk("ivalid_unexpected", 32'(IValid), 32'd0);
                end else begin
                    e = exp_i.pop_front();
                    chk("ireaddata", IReadData, e.data);
                    last_i = e.data;
                end
            end else begin
                if (exp_i.size() > 0 && exp_i[0].t < $time) begin
                    chk("ivalid_missing", 32'(IValid), 32'd1);
                    void'(exp_i.pop_front());
                end
                chk("ireaddata_hold", IReadData, last_i);
            end
            if (DValid) begin
                if (exp_d.size() == 0 || exp_d[0].t >= $time) begin
                    chk("dvalid_unexpected", 32'(DValid), 32'd0);
                end else begin
                    e = exp_d.pop_front();
                    if (e.we) begin
                        chk("dreaddata_after_write", DReadData, last_d);
                    end else begin
                        chk("dreaddata", DReadData, e.data);
                        last_d = e.data;
                    end
                end
            end else begin
                if (exp_d.size() > 0 && exp_d[0].t < $time) begin
                    chk("dvalid_missing", 32'(DValid), 32'd1);
                    void'(exp_d.pop_front());
                end
                chk("dreaddata_hold", DReadData, last_d);
            end
        end
    end

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] base;
        base = ($urandom_range(0, 1) == 1) ? 14'h3FF0 : 14'h0000;
        return base | AW'($urandom_range(0, 15));
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic new_i(input logic [AW-1:0] a);
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic new_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while ((i_req || d_req) && n < 50) begin
            tick();
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
            n++;
        end
        if (i_req || d_req) begin
            chk("grant_timeout", 32'(i_req || d_req), 32'd0);
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(posedge Clock);
        #3 Reset = 1'b0;

        // Lone fetch of a preloaded word.
        tick();
        new_i(14'h0005);
        run_until_idle();
        chk("lone_fetch", IReadData, 32'hDEAD_BEEF);

        // Write the top word, then read it back.
        tick();
        new_d(1'b1, 14'h3FFF, 32'h1234_5678);
        run_until_idle();
        tick();
        new_d(1'b0, 14'h3FFF, 32'h0);
        run_until_idle();
        chk("write_then_read", DReadData, 32'h1234_5678);

        // Simultaneous single requests: data first, fetch next cycle.
        tick();
        new_i(pick_addr());
        new_d(1'b0, pick_addr(), 32'h0);
        run_until_idle();

        // Sustained contention for 12 cycles, ending with an abandoned data write.
        tick();
        tick();
        count_en = 1'b1;
        new_i(pick_addr());
        new_d(1'b0, pick_addr(), 32'h0);
        for (int n = 0; n < 11; n++) begin
            tick();
            if (i_done) new_i(pick_addr());
            if (d_done) new_d((n == 10) ? 1'b1 : 1'($urandom_range(0, 1)), pick_addr(), $urandom);
        end
        tick();
        count_en = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        chk("contention_igrants", 32'(n_ig), 32'd3);
        chk("contention_dgrants", 32'(n_dg), 32'd9);

        // Reset asserted mid-cycle while a data Valid is in flight and DReq is high.
        tick();
        new_d(1'b0, 14'h0005, 32'h0);
        tick();
        new_d(1'b0, 14'h3FFF, 32'h0);
        #2 Reset = 1'b1;
        @(posedge Clock);
        #3 Reset = 1'b0;
        run_until_idle();
        chk("post_reset_read", DReadData, 32'h1234_5678);

        // Random traffic with occasional abandoned requests.
        for (int n = 0; n < 1500; n++) begin
            tick();
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
            if (i_req && !i_done && $urandom_range(0, 15) == 0) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 2) != 0) new_i(pick_addr());
            if (d_req && !d_done && $urandom_range(0, 15) == 0) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 1) == 1) new_d(1'($urandom_range(0, 1)), pick_addr(), $urandom);
        end
        tick();
        if (i_done) i_req = 1'b0;
        if (d_done) d_req = 1'b0;
        run_until_idle();
        repeat (3) tick();
        chk("fetch_queue_drained", 32'(exp_i.size()), 32'd0);
        chk("data_queue_drained", 32'(exp_d.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
